fft_bitrev_reorder: RTL
=======================

Name: fft_bitrev_reorder

Overview:
- Output stage placed directly after the last radix-2 SDF butterfly/delay stage of the SDF-FFT pipeline.
- The SDF pipeline emits each complex frame in bit-reversed index order. This block buffers each frame and replays it in natural order.
- It uses two ping-pong banks: one bank is written while the other is read. The output stream then feeds the spectrum/magnitude logic.

Parameters:
- N_LOG2, 4, log2 of FFT frame length; N = 2**N_LOG2 (minimum 1).
- WIDTH, 16, bit width of each real and imaginary component.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr  input  1  synchronous active-high reset.
- in_valid  input  1  input sample valid this cycle.
- in_first  input  1  marks sample index 0 of a frame; qualified by in_valid.
- in_re  input  WIDTH  real part, bit-reversed order.
- in_im  input  WIDTH  imaginary part, bit-reversed order.
- out_valid  output  1  output sample valid.
- out_first  output  1  high with natural-order index 0.
- out_re  output  WIDTH  real part, natural order.
- out_im  output  WIDTH  imaginary part, natural order.
- frame_err  output  1  sticky: a partial frame was discarded by in_first resync.

Behaviour:
- Clocking/reset:
  - One clock (clk). Reset clr is synchronous and active-high.
  - While clr=1 at an edge: out_valid=0, out_first=0, out_re=0, out_im=0, frame_err=0.
  - Also cleared on reset: wr_cnt=0, wr_bank=0, rd_active=0, rd_cnt=0, rd_bank=0.
  - Memory contents are not cleared.
  - Reset mid-frame or mid-read: the partial write is discarded, the read is aborted, and out_valid is low from the next cycle.
- Storage:
  - Two banks of N entries of 2*WIDTH bits each, indexed [bank][addr].
  - Write and read always target different banks, so there is no read-during-write hazard.
- Write side, on in_valid=1:
  - mem[wr_bank][wr_cnt] <= {in_re,in_im}.
  - wr_cnt increments, wrapping from N-1 to 0.
- Resync:
  - If in_valid=1 and in_first=1 and wr_cnt!=0: set frame_err. The sample is written at address 0 of the current wr_bank and wr_cnt <= 1.
  - in_first=1 with in_valid=0 is ignored.
- Frame complete: when a write occurs with wr_cnt==N-1 (the write wraps wr_cnt to 0):
  - wr_bank toggles.
  - Read start: rd_active<=1, rd_cnt<=0, rd_bank<=old wr_bank.
- Read side, each cycle rd_active=1:
  - {out_re,out_im} <= mem[rd_bank][bitrev(rd_cnt)], where bitrev reverses N_LOG2 bits.
  - out_valid<=1; out_first<=(rd_cnt==0); rd_cnt++.
  - When rd_cnt==N-1 with no new start that cycle: rd_active<=0.
- Read idle: each cycle rd_active=0, out_valid<=0 and out_first<=0. out_re/out_im hold their last value.
- Simultaneous read finish and new start: the start wins. rd_active stays 1, rd_cnt<=0, rd_bank switches, so output is gapless.
- No overflow: a frame write needs at least N cycles, so the previous read (exactly N cycles) always finishes in time.
- Latency: last input sample of frame written at edge t → out_valid=1 with out_first=1 after edge t+1. All N outputs follow on consecutive cycles regardless of input gaps.
- No backpressure: downstream must accept one sample per cycle while out_valid=1.

Optional Feature:
- Macro: FFT_REORDER_ERRCNT_EN.
- When defined:
  - Adds output port err_cnt [7:0]: count of discarded partial frames.
  - Increments on each resync event (same condition that sets frame_err) and saturates at 255.
  - Cleared by clr.
- When undefined: the port and counter are absent. frame_err behaviour is unchanged.

Test Plan:
- Natural-order replay, N_LOG2=4: apply 16 consecutive samples, in_re=k, in_im=100+k, in_first on k=0.
  → out_re = 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15; out_im = 100+out_re; out_first only on the first output; first out_valid two edges after the 16th input.
- Back-to-back frames: 48 continuous valid samples.
  → 48 continuous outputs, out_valid never drops between frames, out_first on outputs 0/16/32.
- Gapped input: valid asserted every other cycle for one frame.
  → 16 contiguous outputs start two edges after the last input; out_valid=0 before and after.
- Resync: 5 samples, then in_first with a new 16-sample frame.
  → frame_err=1; only the new frame is output, correctly ordered; err_cnt=1 with FFT_REORDER_ERRCNT_EN defined.
- Reset mid-read: assert clr after 6 outputs.
  → out_valid=0 and frame_err=0 the next cycle; a subsequent full frame is replayed correctly from bank 0.
- Parameter N_LOG2=3, in_re=k.
  → out_re = 0,4,2,6,1,5,3,7.

Source files
------------

// File: rtl/fft_bitrev_reorder.sv
// rtl/fft_bitrev_reorder.sv - ping-pong reorder buffer, bit-reversed FFT frames in, natural order out
//
// Purpose: sits after the last SDF butterfly stage. Each N-sample frame arrives in
// bit-reversed index order and is written linearly into one bank. When the frame is
// complete it is replayed from that bank in natural order while the next frame fills
// the other bank.
//
// Optional feature macro: FFT_REORDER_ERRCNT_EN (adds err_cnt, a saturating count of
// partial frames discarded by in_first resync).
//
// Ports:
//   clk        in   clock, all state on rising edge
//   clr        in   synchronous active-high reset
//   in_valid   in   input sample valid
//   in_first   in   sample index 0 of a frame (qualified by in_valid)
//   in_re/im   in   WIDTH-bit sample, bit-reversed order
//   out_valid  out  output sample valid
//   out_first  out  natural-order index 0
//   out_re/im  out  WIDTH-bit sample, natural order (held while idle)
//   frame_err  out  sticky partial-frame-discarded flag
//   err_cnt    out  [7:0] discarded frame count (FFT_REORDER_ERRCNT_EN only)

module fft_bitrev_reorder #(
  parameter int N_LOG2 = 4,
  parameter int WIDTH  = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  output logic             out_valid,
  output logic             out_first,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im,
  output logic             frame_err
`ifdef FFT_REORDER_ERRCNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  localparam int N = 1 << N_LOG2;

  logic [2*WIDTH-1:0] r_mem [0:1][0:N-1];

  logic [N_LOG2-1:0] r_wr_cnt;
  logic              r_wr_bank;
  logic              r_rd_active;
  logic [N_LOG2-1:0] r_rd_cnt;
  logic              r_rd_bank;
  logic              r_out_valid;
  logic              r_out_first;
  logic [WIDTH-1:0]  r_out_re;
  logic [WIDTH-1:0]  r_out_im;
  logic              r_frame_err;

  logic              w_resync;
  logic              w_wr_last;
  logic [N_LOG2-1:0] w_wr_addr;
  logic [N_LOG2-1:0] w_rd_addr;

  // A resync restarts the frame at address 0, so it can never complete a frame.
  assign w_resync  = in_valid && in_first && (r_wr_cnt != '0);
  assign w_wr_last = in_valid && !w_resync && (&r_wr_cnt);
  assign w_wr_addr = w_resync ? '0 : r_wr_cnt;

  genvar g;
  generate
    for (g = 0; g < N_LOG2; g++) begin : g_bitrev
      assign w_rd_addr[g] = r_rd_cnt[N_LOG2-1-g];
    end
  endgenerate

  // Memory is not reset; writes are simply suppressed while clr is high.
  always_ff @(posedge clk) begin
    if (in_valid && !clr) begin
      r_mem[r_wr_bank][w_wr_addr] <= {in_re, in_im};
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_wr_cnt    <= '0;
      r_wr_bank   <= 1'b0;
      r_rd_active <= 1'b0;
      r_rd_cnt    <= '0;
      r_rd_bank   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_first <= 1'b0;
      r_out_re    <= '0;
      r_out_im    <= '0;
      r_frame_err <= 1'b0;
    end else begin
      if (in_valid) begin
        if (w_resync) begin
          r_wr_cnt    <= N_LOG2'(1);
          r_frame_err <= 1'b1;
        end else begin
          r_wr_cnt <= r_wr_cnt + N_LOG2'(1);
        end
        if (w_wr_last) begin
          r_wr_bank <= ~r_wr_bank;
        end
      end

      if (r_rd_active) begin
        r_out_valid           <= 1'b1;
        r_out_first           <= (r_rd_cnt == '0);
        {r_out_re, r_out_im}  <= r_mem[r_rd_bank][w_rd_addr];
        r_rd_cnt              <= r_rd_cnt + N_LOG2'(1);
        if (&r_rd_cnt) begin
          r_rd_active <= 1'b0;
        end
      end else begin
        r_out_valid <= 1'b0;
        r_out_first <= 1'b0;
      end

      // Placed last so a new frame start overrides the end of the current read,
      // giving gapless back-to-back output.
      if (w_wr_last) begin
        r_rd_active <= 1'b1;
        r_rd_cnt    <= '0;
        r_rd_bank   <= r_wr_bank;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_first = r_out_first;
  assign out_re    = r_out_re;
  assign out_im    = r_out_im;
  assign frame_err = r_frame_err;

`ifdef FFT_REORDER_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_err_cnt <= 8'd0;
    end else if (w_resync && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule
